// File: rtl/fft_pkg.sv
// Shared FFT datapath package: width constants and complex sample/twiddle types.
//   DATA_W  : sample component width (signed)
//   TW_W    : twiddle component width (signed Q1.11)
//   TW_FRAC : twiddle fractional bits
//   ADDR_W  : twiddle ROM address width (frame length 2**ADDR_W)
package fft_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TW_W    = 12;
    localparam int unsigned TW_FRAC = 11;
    localparam int unsigned ADDR_W  = 4;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } tw_t;

endpackage

// File: rtl/fft_st4_twmul_if.sv
// Bus bundle for the stage-4 twiddle multiplier.
//   in_valid/in_re/in_im          : sample stream from the stage-4 butterfly
//   tw_addr/tw_valid/tw_re/tw_im  : twiddle ROM read port (1-cycle registered ROM)
//   out_valid/out_re/out_im/out_last : product stream to the next stage
// Modport slave is the multiplier; master is the surrounding datapath (butterfly, ROM, sink).
interface fft_st4_twmul_if;
    import fft_pkg::*;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic [ADDR_W-1:0]        tw_addr;
    logic                     tw_valid;
    logic signed [TW_W-1:0]   tw_re;
    logic signed [TW_W-1:0]   tw_im;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic                     out_last;

    modport slave (
        input  in_valid, in_re, in_im, tw_re, tw_im,
        output tw_addr, tw_valid, out_valid, out_re, out_im, out_last
    );

    modport master (
        output in_valid, in_re, in_im, tw_re, tw_im,
        input  tw_addr, tw_valid, out_valid, out_re, out_im, out_last
    );

endinterface

// File: rtl/cmult_q11.sv
// Pipelined complex multiply by a Q1.(TW_FRAC) twiddle with round-half-up and saturation.
// Three register stages: products, sum/difference, round/saturate.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_last   : sideband qualifying a_*/b_* this cycle
//   a_re, a_im          : sample (DATA_W, signed)
//   b_re, b_im          : twiddle (TW_W, signed)
//   out_valid, out_last : sideband delayed by three cycles
//   out_re, out_im      : result; holds while out_valid is low
module cmult_q11 #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TW_W    = 12,
    parameter int unsigned TW_FRAC = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [TW_W-1:0]   b_re,
    input  logic signed [TW_W-1:0]   b_im,
    output logic                     out_valid,
    output logic                     out_last,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im
);

    localparam int unsigned PW = DATA_W + TW_W;  // product width
    localparam int unsigned SW = PW + 1;         // sum width, cannot wrap

    localparam logic signed [SW-1:0] RND   = SW'(1 << (TW_FRAC - 1));
    localparam logic signed [SW-1:0] Y_MAX = SW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0] Y_MIN = SW'(-(1 << (DATA_W - 1)));

    logic                 s2_valid, s2_last;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 s3_valid, s3_last;
    logic signed [SW-1:0] s3_re, s3_im;

    // Floor after adding half an LSB gives round-half-up, also for negative values.
    function automatic logic signed [DATA_W-1:0] rnd_sat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] r;
        r = (x + RND) >>> TW_FRAC;
        if (r > Y_MAX) begin
            return Y_MAX[DATA_W-1:0];
        end else if (r < Y_MIN) begin
            return Y_MIN[DATA_W-1:0];
        end
        return r[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ri      <= '0;
            p_ir      <= '0;
            s3_valid  <= 1'b0;
            s3_last   <= 1'b0;
            s3_re     <= '0;
            s3_im     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            s2_valid  <= in_valid;
            s2_last   <= in_last;
            s3_valid  <= s2_valid;
            s3_last   <= s2_last;
            out_valid <= s3_valid;
            out_last  <= s3_last;
            if (in_valid) begin
                // Operands sign-extended to the product width before multiplying.
                p_rr <= PW'(a_re) * PW'(b_re);
                p_ii <= PW'(a_im) * PW'(b_im);
                p_ri <= PW'(a_re) * PW'(b_im);
                p_ir <= PW'(a_im) * PW'(b_re);
            end
            if (s2_valid) begin
                s3_re <= SW'(p_rr) - SW'(p_ii);
                s3_im <= SW'(p_ri) + SW'(p_ir);
            end
            if (s3_valid) begin
                out_re <= rnd_sat(s3_re);
                out_im <= rnd_sat(s3_im);
            end
        end
    end

endmodule

// File: rtl/fft_st4_twmul.sv
// Stage-4 twiddle multiplier. Counts samples within a 2**ADDR_W frame, drives the twiddle ROM
// with the current index, aligns the sample with the ROM's one-cycle read latency and feeds the
// pair to cmult_q11. Latency from in_valid to out_valid is four cycles; no backpressure.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fft_st4_twmul_if.slave (sample in, ROM port, product out)
module fft_st4_twmul #(
    parameter int unsigned DATA_W  = fft_pkg::DATA_W,
    parameter int unsigned TW_W    = fft_pkg::TW_W,
    parameter int unsigned TW_FRAC = fft_pkg::TW_FRAC,
    parameter int unsigned ADDR_W  = fft_pkg::ADDR_W
) (
    input logic            clk,
    input logic            rst,
    fft_st4_twmul_if.slave bus
);

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    logic [ADDR_W-1:0]        idx;
    logic                     s1_valid, s1_last;
    logic signed [DATA_W-1:0] s1_re, s1_im;

    always_comb begin
        bus.tw_addr  = idx;
        bus.tw_valid = bus.in_valid;
    end

    // Index advances only on valid samples, so frame position survives input gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_valid && (idx == IDX_LAST);
            if (bus.in_valid) begin
                idx   <= idx + ADDR_W'(1);
                s1_re <= bus.in_re;
                s1_im <= bus.in_im;
            end
        end
    end

    // ROM data arrives in the same cycle as the S1 registers.
    cmult_q11 #(
        .DATA_W  (DATA_W),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC)
    ) u_cmult (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_last   (s1_last),
        .a_re      (s1_re),
        .a_im      (s1_im),
        .b_re      (bus.tw_re),
        .b_im      (bus.tw_im),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last),
        .out_re    (bus.out_re),
        .out_im    (bus.out_im)
    );

endmodule
